stage_pipe_buf: RTL and testbench

Parametrised elastic pipeline-stage buffer: the next generation of the fixed-width, single-entry inter-stage registers. It carries an arbitrary-width stage bundle through a DEPTH-entry FIFO with valid/ready handshake on both sides. It also supports an unconditional flush and a stall-qualified kill for branch/trap redirects. It sits between any two core pipeline stages (IF/ID, ID/EX, EX/MEM) and replaces the clear/stall flop.

---
 rtl/pipe_pkg.sv | 63 ++++++
 rtl/stage_pipe_buf_if.sv | 40 ++++
 rtl/stage_pipe_buf.sv | 98 +++++++++
 tb/tb_stage_pipe_buf.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-bundle definitions.
//
// Purpose: one place that fixes the packed layout of each inter-stage bundle,
// so that the elastic stage buffers between IF/ID, ID/EX and EX/MEM are sized
// from the bundle type rather than from hand-counted widths.
//
// Contents:
//   alu_op_e  - ALU operation encoding carried in the ID/EX bundle
//   if_id_t   - fetch -> decode bundle
//   id_ex_t   - decode -> execute bundle (342 bits)
//   ex_mem_t  - execute -> memory bundle
//   IF_ID_W / ID_EX_W / EX_MEM_W - packed widths of the bundles above
package pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic [63:0] imm;
    logic [31:0] instr;
    logic [11:0] csr_addr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    alu_op_e     alu_op;
    logic [15:0] ctrl;
    logic [1:0]  mem_size;
    logic [1:0]  priv;
  } id_ex_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] alu_res;
    logic [63:0] store_data;
    logic [4:0]  rd;
    logic [1:0]  mem_size;
    logic [7:0]  ctrl;
  } ex_mem_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);

endpackage

// File: rtl/stage_pipe_buf_if.sv
// Handshake bundle for one elastic pipeline-stage buffer.
//
// Purpose: groups the upstream valid/ready/data, downstream valid/ready/data,
// redirect controls and occupancy so a stage buffer is wired with one port.
//
// Signals:
//   in_valid/in_ready/in_data    - upstream side (producer -> buffer)
//   out_valid/out_ready/out_data - downstream side (buffer -> consumer)
//   flush                        - unconditional discard of all entries
//   kill                         - redirect discard, honoured only when not stalled
//   count                        - occupied entries
// Modports:
//   slave  - the buffer itself
//   master - the surrounding pipeline (drives inputs, observes outputs)
interface stage_pipe_buf_if #(
  parameter int WIDTH = pipe_pkg::ID_EX_W,
  parameter int DEPTH = 2
);

  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic                       flush;
  logic                       kill;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport slave (
    input  in_valid, in_data, out_ready, flush, kill,
    output in_ready, out_valid, out_data, count
  );

  modport master (
    output in_valid, in_data, out_ready, flush, kill,
    input  in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/stage_pipe_buf.sv
// Elastic pipeline-stage buffer.
//
// Purpose: carries a WIDTH-bit stage bundle through a DEPTH-entry FIFO with
// valid/ready on both sides, replacing the clear/stall flop between two core
// pipeline stages. Supports an unconditional flush and a kill that only takes
// effect when the head is not stalled downstream.
//
// Parameters:
//   WIDTH     - packed bundle width (default: ID/EX bundle)
//   DEPTH     - number of entries, any integer >= 1
//   RESET_VAL - value presented on out_data while out_valid = 0
// Ports:
//   clk - clock, all state on rising edge
//   rst - asynchronous, active-high reset
//   bus - stage_pipe_buf_if.slave handshake bundle
module stage_pipe_buf
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = ID_EX_W,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  stage_pipe_buf_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;

  logic not_empty;
  logic full;
  logic stalled;
  logic kill_eff;
  logic clear;
  logic push;
  logic pop;

  // DEPTH need not be a power of two, so wrap explicitly instead of relying
  // on the pointer overflowing.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));

  // A stalled head must not be discarded out from under the consumer; the
  // redirect source holds kill until the stall clears.
  assign stalled  = not_empty & ~bus.out_ready;
  assign kill_eff = bus.kill & ~stalled;
  assign clear    = bus.flush | kill_eff;

  // Readiness never looks at a same-cycle pop: a full buffer refuses input
  // even when the consumer is draining. out_ready reaches in_ready only
  // through the kill qualification.
  assign bus.in_ready = ~full & ~bus.flush & ~kill_eff;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = not_empty & bus.out_ready;

  assign bus.out_valid = not_empty;
  assign bus.out_data  = not_empty ? storage[rd_ptr] : RESET_VAL;
  assign bus.count     = count_q;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      // The same-cycle pop has already been seen downstream; dropping the
      // rest and rewinding both pointers completes it.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: the payload array has no reset; count gates out_data, so stale
  // contents are never observable and the wide storage needs no reset net.
  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr] <= bus.in_data;
  end

endmodule

// File: tb/tb_stage_pipe_buf.sv
// Self-checking bench for stage_pipe_buf.
//
// Two instances share clk/rst: a DEPTH=2 buffer with a non-zero RESET_VAL and
// a DEPTH=3 buffer with RESET_VAL='0. A queue per instance models the FIFO;
// every step compares in_ready, out_valid, count and out_data against it.
module tb_stage_pipe_buf;
  import pipe_pkg::*;

  localparam int               W   = ID_EX_W;
  localparam logic [W-1:0]     RV2 = W'(128'hDEAD_BEEF_0BAD_F00D_5A5A_C3C3_1234_5678);
  localparam logic [W-1:0]     RV3 = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage_pipe_buf_if #(.WIDTH(W), .DEPTH(2)) b2 ();
  stage_pipe_buf_if #(.WIDTH(W), .DEPTH(3)) b3 ();

  stage_pipe_buf #(.WIDTH(W), .DEPTH(2), .RESET_VAL(RV2)) u2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  stage_pipe_buf #(.WIDTH(W), .DEPTH(3), .RESET_VAL(RV3)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  string       phase       = "init";

  logic [W-1:0] q2[$];
  logic [W-1:0] q3[$];

  function automatic logic [W-1:0] mk(input int unsigned v);
    logic [W-1:0] x;
    x = W'(v);
    return x | (x << 320) | (x << 160);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  // One cycle on the DEPTH=2 instance: drive, check at negedge, update model.
  task automatic step2(input logic vi, input logic [W-1:0] d, input logic ordy,
                       input logic fl, input logic kl, output logic pushed);
    logic ev, ek, er;
    logic [W-1:0] ed;
    b2.in_valid = vi; b2.in_data = d; b2.out_ready = ordy;
    b2.flush = fl; b2.kill = kl;
    @(negedge clk);
    ev = (q2.size() != 0);
    ek = kl & ~(ev & ~ordy);
    er = (q2.size() != 2) & ~fl & ~ek;
    ed = RV2;
    if (ev) ed = q2[0];
    check("d2.in_ready",  W'(b2.in_ready),  W'(er));
    check("d2.out_valid", W'(b2.out_valid), W'(ev));
    check("d2.count",     W'(b2.count),     W'(q2.size()));
    check("d2.out_data",  b2.out_data,      ed);
    pushed = vi & er;
    if (ev & ordy) void'(q2.pop_front());
    if (fl | ek) q2.delete();
    else if (pushed) q2.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic step3(input logic vi, input logic [W-1:0] d, input logic ordy,
                       input logic fl, input logic kl, output logic pushed);
    logic ev, ek, er;
    logic [W-1:0] ed;
    b3.in_valid = vi; b3.in_data = d; b3.out_ready = ordy;
    b3.flush = fl; b3.kill = kl;
    @(negedge clk);
    ev = (q3.size() != 0);
    ek = kl & ~(ev & ~ordy);
    er = (q3.size() != 3) & ~fl & ~ek;
    ed = RV3;
    if (ev) ed = q3[0];
    check("d3.in_ready",  W'(b3.in_ready),  W'(er));
    check("d3.out_valid", W'(b3.out_valid), W'(ev));
    check("d3.count",     W'(b3.count),     W'(q3.size()));
    check("d3.out_data",  b3.out_data,      ed);
    pushed = vi & er;
    if (ev & ordy) void'(q3.pop_front());
    if (fl | ek) q3.delete();
    else if (pushed) q3.push_back(d);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p;
    int   pushes;
    b2.in_valid = 0; b2.in_data = '0; b2.out_ready = 0; b2.flush = 0; b2.kill = 0;
    b3.in_valid = 0; b3.in_data = '0; b3.out_ready = 0; b3.flush = 0; b3.kill = 0;

    // Power-on reset.
    phase = "reset";
    repeat (2) @(posedge clk);
    #1;
    check("d2.out_valid", W'(b2.out_valid), '0);
    check("d2.count",     W'(b2.count),     '0);
    check("d2.out_data",  b2.out_data,      RV2);
    check("d3.out_data",  b3.out_data,      RV3);
    rst = 1'b0;
    @(negedge clk);
    check("d2.in_ready",  W'(b2.in_ready),  W'(1));
    check("d3.in_ready",  W'(b3.in_ready),  W'(1));
    @(posedge clk); #1;

    // Back-to-back streaming through DEPTH=2.
    phase = "stream";
    for (int i = 1; i <= 8; i++) step2(1'b1, mk(i), 1'b1, 1'b0, 1'b0, p);
    repeat (2) step2(1'b0, '0, 1'b1, 1'b0, 1'b0, p);

    // Backpressure on DEPTH=3: four offered while stalled, then release.
    phase = "bp";
    for (int i = 0; i < 3; i++) step3(1'b1, mk(16'h11 + i), 1'b0, 1'b0, 1'b0, p);
    step3(1'b1, mk(16'h14), 1'b0, 1'b0, 1'b0, p);
    step3(1'b1, mk(16'h14), 1'b1, 1'b0, 1'b0, p);
    step3(1'b1, mk(16'h14), 1'b1, 1'b0, 1'b0, p);
    for (int g = 0; g < 8; g++) step3(1'b0, '0, 1'b1, 1'b0, 1'b0, p);

    // Pointer wrap on DEPTH=3 with random consumer stalls.
    phase  = "wrap";
    pushes = 0;
    for (int g = 0; g < 200 && pushes < 10; g++) begin
      step3(1'b1, mk(32'h100 + pushes), 1'($urandom_range(0, 1)), 1'b0, 1'b0, p);
      if (p) pushes++;
    end
    for (int g = 0; g < 50 && q3.size() != 0; g++)
      step3(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, p);
    step3(1'b0, '0, 1'b1, 1'b0, 1'b0, p);
    check("d3.drained", W'(b3.count), '0);

    // Kill held during a stall, then honoured at the first unstalled edge.
    phase = "kill";
    step2(1'b1, mk(16'h21), 1'b0, 1'b0, 1'b0, p);
    step2(1'b1, mk(16'h22), 1'b0, 1'b0, 1'b0, p);
    step2(1'b0, '0, 1'b0, 1'b0, 1'b1, p);
    step2(1'b0, '0, 1'b0, 1'b0, 1'b1, p);
    step2(1'b0, '0, 1'b1, 1'b0, 1'b1, p);
    step2(1'b0, '0, 1'b1, 1'b0, 1'b0, p);

    // Flush with an offered bundle and two entries held.
    phase = "flush";
    step2(1'b1, mk(16'h31), 1'b0, 1'b0, 1'b0, p);
    step2(1'b1, mk(16'h32), 1'b0, 1'b0, 1'b0, p);
    step2(1'b1, mk(16'h33), 1'b0, 1'b1, 1'b0, p);
    step2(1'b0, '0, 1'b1, 1'b0, 1'b0, p);
    step2(1'b0, '0, 1'b1, 1'b0, 1'b0, p);

    // Flush and kill together while stalled: flush wins.
    phase = "flushkill";
    step2(1'b1, mk(16'h41), 1'b0, 1'b0, 1'b0, p);
    step2(1'b1, mk(16'h42), 1'b0, 1'b1, 1'b1, p);
    step2(1'b0, '0, 1'b1, 1'b0, 1'b0, p);

    // Asynchronous reset mid-run with two entries held.
    phase = "midreset";
    step2(1'b1, mk(16'h51), 1'b0, 1'b0, 1'b0, p);
    step2(1'b1, mk(16'h52), 1'b0, 1'b0, 1'b0, p);
    b2.in_valid = 0; b2.out_ready = 0;
    check("d2.count_before", W'(b2.count), W'(2));
    #2 rst = 1'b1;
    #1;
    check("d2.count",     W'(b2.count),     '0);
    check("d2.out_valid", W'(b2.out_valid), '0);
    check("d2.out_data",  b2.out_data,      RV2);
    q2.delete();
    q3.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("d2.in_ready",  W'(b2.in_ready),  W'(1));
    @(posedge clk); #1;
    step2(1'b1, mk(16'h61), 1'b1, 1'b0, 1'b0, p);
    step2(1'b0, '0, 1'b1, 1'b0, 1'b0, p);
    step2(1'b0, '0, 1'b1, 1'b0, 1'b0, p);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
